// File: rtl/dm_unit.sv
// Data-memory unit sitting behind the CPU MEM stage.
// Word-organised RAM with byte/halfword lane handling, plus a small MMIO
// page holding the LED register, synchronised switches, a free-running
// cycle counter and a sticky misaligned/invalid-access status flag.
// Loads are combinational; stores take effect on the next rising edge.

module dm_unit #(
    parameter int          ADDR_W  = 7,
    parameter logic [15:0] MMIO_HI = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_w,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  dm_ctrl,
    output logic [31:0] rdata,
    input  logic [15:0] sw_i,
    output logic [15:0] led_o,
    output logic        misalign_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0]       mem [0:DEPTH-1];

    logic              is_mmio;
    logic [ADDR_W-1:0] ram_idx;
    logic [15:0]       mmio_off;

    logic              is_word;
    logic              is_half;
    logic              is_byte;
    logic              is_signed;
    logic              bad;

    logic              good_store;
    logic              ram_we;
    logic              sel_led;
    logic              sel_sw;
    logic              sel_cycle;
    logic              sel_status;

    logic [3:0]        byte_en;
    logic [31:0]       lane_data;

    logic [31:0]       ram_word;
    logic [15:0]       half_val;
    logic [7:0]        byte_val;
    logic [31:0]       ram_rd;
    logic [31:0]       mmio_rd;

    logic [15:0]       sw_meta;
    logic [15:0]       sw_sync;
    logic [31:0]       cycle_cnt;
    logic              flag;

    assign is_mmio  = (addr[31:16] == MMIO_HI);
    assign ram_idx  = addr[ADDR_W+1:2];
    assign mmio_off = addr[15:0];

    // Decode access size/sign and decide whether the access is malformed
    always_comb begin
        is_word   = 1'b0;
        is_half   = 1'b0;
        is_byte   = 1'b0;
        is_signed = 1'b0;
        case (dm_ctrl)
            3'b000: is_word = 1'b1;
            3'b001: begin is_half = 1'b1; is_signed = 1'b1; end
            3'b010: is_half = 1'b1;
            3'b011: begin is_byte = 1'b1; is_signed = 1'b1; end
            3'b100: is_byte = 1'b1;
            default: ;
        endcase
        bad = !(is_word || is_half || is_byte)
              || (is_half && addr[0])
              || (is_word && (addr[1:0] != 2'b00))
              || (is_mmio && !is_word);
    end

    assign good_store = mem_w && !bad;
    assign ram_we     = good_store && !is_mmio;
    assign sel_led    = is_mmio && (mmio_off == 16'h0000);
    assign sel_sw     = is_mmio && (mmio_off == 16'h0004);
    assign sel_cycle  = is_mmio && (mmio_off == 16'h0008);
    assign sel_status = is_mmio && (mmio_off == 16'h000C);

    // Build per-lane write enables and replicate store data onto every lane
    always_comb begin
        byte_en   = 4'b0000;
        lane_data = wdata;
        if (is_word) begin
            byte_en   = 4'b1111;
        end else if (is_half) begin
            byte_en   = addr[1] ? 4'b1100 : 4'b0011;
            lane_data = {wdata[15:0], wdata[15:0]};
        end else if (is_byte) begin
            byte_en   = 4'b0001 << addr[1:0];
            lane_data = {4{wdata[7:0]}};
        end
    end

    // RAM array is not reset; a store presented while reset is held is dropped
    always_ff @(posedge clk) begin
        if (ram_we && rst) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[ram_idx][8*i +: 8] <= lane_data[8*i +: 8];
                end
            end
        end
    end

    // Extract and extend the addressed lane(s) from the current RAM word
    always_comb begin
        ram_word = mem[ram_idx];
        half_val = addr[1] ? ram_word[31:16] : ram_word[15:0];
        case (addr[1:0])
            2'd0:    byte_val = ram_word[7:0];
            2'd1:    byte_val = ram_word[15:8];
            2'd2:    byte_val = ram_word[23:16];
            default: byte_val = ram_word[31:24];
        endcase
        ram_rd = ram_word;
        if (is_half) begin
            ram_rd = {{16{is_signed & half_val[15]}}, half_val};
        end else if (is_byte) begin
            ram_rd = {{24{is_signed & byte_val[7]}}, byte_val};
        end
    end

    // MMIO read mux; unmapped offsets read as zero
    always_comb begin
        mmio_rd = 32'h0;
        if (sel_led) begin
            mmio_rd = {16'h0, led_o};
        end else if (sel_sw) begin
            mmio_rd = {16'h0, sw_sync};
        end else if (sel_cycle) begin
            mmio_rd = cycle_cnt;
        end else if (sel_status) begin
            mmio_rd = {31'h0, flag};
        end
    end

    assign rdata      = bad ? 32'h0 : (is_mmio ? mmio_rd : ram_rd);
    assign misalign_o = flag;

    // Two-flop synchroniser for the asynchronous board switches
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_meta <= 16'h0;
            sw_sync <= 16'h0;
        end else begin
            sw_meta <= sw_i;
            sw_sync <= sw_meta;
        end
    end

    // LED register, loaded by a good word store to its MMIO slot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_o <= 16'h0;
        end else if (good_store && sel_led) begin
            led_o <= wdata[15:0];
        end
    end

    // Free-running cycle counter; any write clears it and beats the increment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt <= 32'h0;
        end else if (good_store && sel_cycle) begin
            cycle_cnt <= 32'h0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'h1;
        end
    end

    // Sticky misalign flag: a bad store sets it, a status write of 1 clears it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flag <= 1'b0;
        end else if (mem_w && bad) begin
            flag <= 1'b1;
        end else if (good_store && sel_status && wdata[0]) begin
            flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dm_unit.sv
// Directed-vector bench for dm_unit: RAM lane handling, alignment checks,
// MMIO registers, switch synchroniser latency and asynchronous reset.

module tb_dm_unit;

    logic        clk;
    logic        rst;
    logic        mem_w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  dm_ctrl;
    logic [31:0] rdata;
    logic [15:0] sw_i;
    logic [15:0] led_o;
    logic        misalign_o;

    int check_count;
    int error_count;

    localparam logic [2:0] W  = 3'b000;
    localparam logic [2:0] H  = 3'b001;
    localparam logic [2:0] B  = 3'b011;
    localparam logic [2:0] BU = 3'b100;

    localparam logic [31:0] A_LED    = 32'hFFFF0000;
    localparam logic [31:0] A_SW     = 32'hFFFF0004;
    localparam logic [31:0] A_CYCLE  = 32'hFFFF0008;
    localparam logic [31:0] A_STATUS = 32'hFFFF000C;

    dm_unit #(.ADDR_W(7), .MMIO_HI(16'hFFFF)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_w      (mem_w),
        .addr       (addr),
        .wdata      (wdata),
        .dm_ctrl    (dm_ctrl),
        .rdata      (rdata),
        .sw_i       (sw_i),
        .led_o      (led_o),
        .misalign_o (misalign_o)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one access on the falling edge; outputs settle before the next rise
    task automatic applyStimulus(input logic w, input logic [31:0] a,
                                 input logic [31:0] d, input logic [2:0] c);
        @(negedge clk);
        mem_w   = w;
        addr    = a;
        wdata   = d;
        dm_ctrl = c;
        #2;
    endtask

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Guard against a hung run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main directed sequence
    initial begin
        check_count = 0;
        error_count = 0;
        rst     = 1'b0;
        mem_w   = 1'b0;
        addr    = A_CYCLE;
        wdata   = 32'h0;
        dm_ctrl = W;
        sw_i    = 16'h0;

        // Reset state
        #2;
        checkOutput("reset_led", {16'h0, led_o}, 32'h0);
        checkOutput("reset_flag", {31'h0, misalign_o}, 32'h0);
        checkOutput("reset_cycle", rdata, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Counter counts one per edge from reset release
        for (int k = 0; k <= 10; k++) begin
            applyStimulus(1'b0, A_CYCLE, 32'h0, W);
            checkOutput($sformatf("cycle_run_%0d", k), rdata, 32'(k));
        end

        // Any write clears the counter, then it resumes counting
        applyStimulus(1'b1, A_CYCLE, 32'h1234, W);
        applyStimulus(1'b0, A_CYCLE, 32'h0, W);
        checkOutput("cycle_clear", rdata, 32'h0);
        applyStimulus(1'b0, A_CYCLE, 32'h0, W);
        checkOutput("cycle_after_clear", rdata, 32'h1);

        // Word store then sign/zero-extended sub-word loads
        applyStimulus(1'b1, 32'h10, 32'h80001234, W);
        applyStimulus(1'b0, 32'h13, 32'h0, B);
        checkOutput("load_byte_signed", rdata, 32'hFFFFFF80);
        applyStimulus(1'b0, 32'h13, 32'h0, BU);
        checkOutput("load_byte_unsigned", rdata, 32'h00000080);
        applyStimulus(1'b0, 32'h10, 32'h0, H);
        checkOutput("load_half_signed", rdata, 32'h00001234);
        applyStimulus(1'b0, 32'h12, 32'h0, H);
        checkOutput("load_half_hi_signed", rdata, 32'hFFFF8000);
        applyStimulus(1'b0, 32'h12, 32'h0, 3'b010);
        checkOutput("load_half_hi_unsigned", rdata, 32'h00008000);

        // Byte and halfword stores merge into an existing word
        applyStimulus(1'b1, 32'h20, 32'h11223344, W);
        applyStimulus(1'b1, 32'h21, 32'hFFFFFFAB, B);
        applyStimulus(1'b0, 32'h20, 32'h0, W);
        checkOutput("byte_store_merge", rdata, 32'h1122AB44);
        applyStimulus(1'b1, 32'h22, 32'h0000BEEF, H);
        applyStimulus(1'b0, 32'h20, 32'h0, W);
        checkOutput("half_store_merge", rdata, 32'hBEEFAB44);

        // Store and load of the same word in one cycle return the old data
        applyStimulus(1'b1, 32'h40, 32'h11111111, W);
        applyStimulus(1'b1, 32'h40, 32'h22222222, W);
        checkOutput("no_bypass_old", rdata, 32'h11111111);
        applyStimulus(1'b0, 32'h40, 32'h0, W);
        checkOutput("no_bypass_new", rdata, 32'h22222222);

        // Misaligned halfword store is suppressed and flagged
        applyStimulus(1'b1, 32'h30, 32'hCAFEF00D, W);
        applyStimulus(1'b0, 32'h30, 32'h0, 3'b101);
        checkOutput("invalid_ctrl_rdata", rdata, 32'h0);
        applyStimulus(1'b0, 32'h31, 32'h0, H);
        checkOutput("bad_load_rdata", rdata, 32'h0);
        checkOutput("bad_load_not_flagged", {31'h0, misalign_o}, 32'h0);
        applyStimulus(1'b1, 32'h31, 32'h0000DEAD, H);
        applyStimulus(1'b0, 32'h30, 32'h0, W);
        checkOutput("bad_store_suppressed", rdata, 32'hCAFEF00D);
        checkOutput("bad_store_flag", {31'h0, misalign_o}, 32'h1);
        applyStimulus(1'b0, A_STATUS, 32'h0, W);
        checkOutput("status_read_set", rdata, 32'h1);
        applyStimulus(1'b1, A_STATUS, 32'h1, W);
        applyStimulus(1'b1, 32'h34, 32'h5555AAAA, W);
        checkOutput("status_cleared", {31'h0, misalign_o}, 32'h0);
        applyStimulus(1'b0, 32'h34, 32'h0, W);
        checkOutput("good_store_no_flag", {31'h0, misalign_o}, 32'h0);
        checkOutput("good_store_data", rdata, 32'h5555AAAA);

        // Switches appear after two synchroniser edges
        applyStimulus(1'b0, A_SW, 32'h0, W);
        sw_i = 16'h5A5A;
        checkOutput("sw_edge0", rdata, 32'h0);
        applyStimulus(1'b0, A_SW, 32'h0, W);
        checkOutput("sw_edge1", rdata, 32'h0);
        applyStimulus(1'b0, A_SW, 32'h0, W);
        checkOutput("sw_edge2", rdata, 32'h00005A5A);

        // LED register takes the low half of a word store
        applyStimulus(1'b1, A_LED, 32'h0001C3C3, W);
        applyStimulus(1'b0, A_LED, 32'h0, W);
        checkOutput("led_out", {16'h0, led_o}, 32'h0000C3C3);
        checkOutput("led_read", rdata, 32'h0000C3C3);

        // Sub-word access to MMIO is bad: suppressed and flagged
        applyStimulus(1'b1, A_LED, 32'h00000055, B);
        applyStimulus(1'b0, A_CYCLE, 32'h0, W);
        checkOutput("mmio_byte_led_kept", {16'h0, led_o}, 32'h0000C3C3);
        checkOutput("mmio_byte_flag", {31'h0, misalign_o}, 32'h1);

        // Asynchronous reset mid-stream
        rst = 1'b0;
        #1;
        checkOutput("async_rst_led", {16'h0, led_o}, 32'h0);
        checkOutput("async_rst_flag", {31'h0, misalign_o}, 32'h0);
        checkOutput("async_rst_cycle", rdata, 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        applyStimulus(1'b0, A_CYCLE, 32'h0, W);
        checkOutput("cycle_after_rst", rdata, 32'h0);

        // Upper RAM address bits alias onto the same word
        applyStimulus(1'b0, 32'h210, 32'h0, W);
        checkOutput("alias_0x210", rdata, 32'h80001234);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
